// File: rtl/exe_wb_elastic_latch_pkg.sv
// Shared defaults for the EXE->WB elastic latch.
// Holds default widths and the hardwired-zero register address.
package exe_wb_elastic_latch_pkg;

    localparam int XLEN_DEF       = 64;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int INSTR_W_DEF    = 32;
    localparam int ZERO_REG_ADDR  = 0;

    // Packed entry layout: {wdata, waddr, we, instr}
    function automatic int payload_width(
        input int xlen,
        input int addr_w,
        input int instr_w
    );
        return xlen + addr_w + 1 + instr_w;
    endfunction

endpackage

// File: rtl/exe_wb_elastic_latch_pipe_payload_reg.sv
// Load-enabled payload register for one latch entry.
// Clears asynchronously; holds its value unless load is high.
module exe_wb_elastic_latch_pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Next value: capture on load, otherwise hold
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    // Storage with asynchronous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/exe_wb_elastic_latch.sv
// EXE->WB pipeline latch with valid/ready handshake and one-entry skid.
// Head drives writeback and the forwarding tap; skid absorbs WB stalls.
module exe_wb_elastic_latch
    import exe_wb_elastic_latch_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int ADDR_W   = REG_ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               exe_valid,
    output logic               exe_ready,
    input  logic [XLEN-1:0]    exe_wdata,
    input  logic [ADDR_W-1:0]  exe_waddr,
    input  logic               exe_we,
    input  logic [INSTR_W-1:0] exe_instr,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [XLEN-1:0]    wb_wdata,
    output logic [ADDR_W-1:0]  wb_waddr,
    output logic               wb_we,
    output logic [INSTR_W-1:0] wb_instr,
    output logic               fwd_valid,
    output logic [ADDR_W-1:0]  fwd_addr,
    output logic [XLEN-1:0]    fwd_data,
    output logic               skid_full
);

    localparam int PW = payload_width(XLEN, ADDR_W, INSTR_W);

    logic          head_valid_d;
    logic          head_valid_q;
    logic          skid_valid_d;
    logic          skid_valid_q;
    logic          head_load;
    logic          skid_load;
    logic          head_from_skid;
    logic          in_fire;
    logic          out_fire;
    logic          head_we;
    logic          waddr_nonzero;
    logic [PW-1:0] exe_payload;
    logic [PW-1:0] head_in;
    logic [PW-1:0] head_payload;
    logic [PW-1:0] skid_payload;

    // Ready depends only on registered state, never on wb_ready
    assign exe_ready = !skid_valid_q;
    assign in_fire   = exe_valid && exe_ready;
    assign out_fire  = head_valid_q && wb_ready;

    assign exe_payload = {exe_wdata, exe_waddr, exe_we, exe_instr};

    // Occupancy and load control; flush overrides every other event
    always_comb begin
        head_valid_d   = head_valid_q;
        skid_valid_d   = skid_valid_q;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!head_valid_q) begin
            if (in_fire) begin
                head_valid_d = 1'b1;
                head_load    = 1'b1;
            end
        end else if (out_fire) begin
            if (skid_valid_q) begin
                head_load      = 1'b1;
                head_from_skid = 1'b1;
                skid_valid_d   = 1'b0;
            end else if (in_fire) begin
                head_load = 1'b1;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    // Valid bits for head and skid entries
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign head_in = head_from_skid ? skid_payload : exe_payload;

    exe_wb_elastic_latch_pipe_payload_reg #(
        .W (PW)
    ) u_head (
        .clock (clock),
        .reset (reset),
        .load  (head_load),
        .d     (head_in),
        .q     (head_payload)
    );

    exe_wb_elastic_latch_pipe_payload_reg #(
        .W (PW)
    ) u_skid (
        .clock (clock),
        .reset (reset),
        .load  (skid_load),
        .d     (exe_payload),
        .q     (skid_payload)
    );

    assign {wb_wdata, wb_waddr, head_we, wb_instr} = head_payload;

    assign wb_valid  = head_valid_q;
    assign wb_we     = head_we && head_valid_q;
    assign skid_full = skid_valid_q;

    // Writes to the hardwired-zero register are never forwarded
    assign waddr_nonzero = (ZERO_REG == 0) ||
                           (wb_waddr != ADDR_W'(ZERO_REG_ADDR));

    assign fwd_valid = wb_we && waddr_nonzero;
    assign fwd_addr  = wb_waddr;
    assign fwd_data  = wb_wdata;

endmodule

// File: tb/tb_exe_wb_elastic_latch.sv
// Bench for exe_wb_elastic_latch: vector table, corner sequences,
// and a randomized run against a FIFO reference model.
module tb_exe_wb_elastic_latch;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        exe_valid;
    logic        exe_ready;
    logic [63:0] exe_wdata;
    logic [4:0]  exe_waddr;
    logic        exe_we;
    logic [31:0] exe_instr;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_wdata;
    logic [4:0]  wb_waddr;
    logic        wb_we;
    logic [31:0] wb_instr;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        skid_full;

    int tests;
    int failed;

    exe_wb_elastic_latch dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .exe_valid (exe_valid),
        .exe_ready (exe_ready),
        .exe_wdata (exe_wdata),
        .exe_waddr (exe_waddr),
        .exe_we    (exe_we),
        .exe_instr (exe_instr),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_wdata  (wb_wdata),
        .wb_waddr  (wb_waddr),
        .wb_we     (wb_we),
        .wb_instr  (wb_instr),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .skid_full (skid_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] wdata;
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic        f;
        logic        v;
        logic [63:0] wd;
        logic [4:0]  wa;
        logic        we;
        logic        rdy;
        logic        e_valid;
        logic [63:0] e_wdata;
        logic [4:0]  e_waddr;
        logic        e_we;
        logic        e_ready;
        logic        e_skid;
        logic        e_fwd;
    } vec_t;

    entry_t model_q[$];

    function automatic logic [31:0] instr_of(input logic [63:0] wd);
        return wd[31:0] ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic v, input logic [63:0] wd,
                         input logic [4:0] wa, input logic we,
                         input logic rdy);
        flush     = f;
        exe_valid = v;
        exe_wdata = wd;
        exe_waddr = wa;
        exe_we    = we;
        exe_instr = instr_of(wd);
        wb_ready  = rdy;
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        cycle();
        reset = 1'b1;
        model_q.delete();
    endtask

    // Compare all outputs against the FIFO model's view
    task automatic chk_model();
        entry_t h;
        chk("rnd_exe_ready", exe_ready, model_q.size() < 2);
        chk("rnd_skid_full", skid_full, model_q.size() == 2);
        chk("rnd_wb_valid", wb_valid, model_q.size() > 0);
        if (model_q.size() > 0) begin
            h = model_q[0];
            chk("rnd_wb_wdata", wb_wdata, h.wdata);
            chk("rnd_wb_waddr", wb_waddr, h.waddr);
            chk("rnd_wb_instr", wb_instr, h.instr);
            chk("rnd_wb_we", wb_we, h.we);
            chk("rnd_fwd_valid", fwd_valid, h.we && (h.waddr != 0));
            chk("rnd_fwd_data", fwd_data, h.wdata);
            chk("rnd_fwd_addr", fwd_addr, h.waddr);
        end else begin
            chk("rnd_wb_we_idle", wb_we, 1'b0);
            chk("rnd_fwd_idle", fwd_valid, 1'b0);
        end
    endtask

    vec_t vecs[$];

    initial begin
        vec_t   t;
        entry_t e;
        logic   in_fire;
        logic   out_fire;
        tests  = 0;
        failed = 0;
        reset  = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0);

        // Reset state
        #12;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_exe_ready", exe_ready, 1'b1);
        chk("rst_skid_full", skid_full, 1'b0);
        chk("rst_wb_wdata", wb_wdata, 64'h0);
        chk("rst_wb_we", wb_we, 1'b0);
        chk("rst_fwd_valid", fwd_valid, 1'b0);
        do_reset();

        // f v wdata waddr we rdy | valid wdata waddr we ready skid fwd
        vecs = '{
            '{0,1,64'hAA,5,1,0, 1,64'hAA,5,1, 1,0,1},
            '{0,1,64'hBB,0,1,0, 1,64'hAA,5,1, 0,1,1},
            '{0,1,64'hCC,0,1,0, 1,64'hAA,5,1, 0,1,1},
            '{0,1,64'hCC,7,1,1, 1,64'hBB,0,1, 1,0,0},
            '{0,1,64'hCC,7,1,1, 1,64'hCC,7,1, 1,0,1},
            '{0,0,64'h0,0,0,1,  0,64'h0,0,0,  1,0,0},
            '{0,1,64'h11,3,1,0, 1,64'h11,3,1, 1,0,1},
            '{0,1,64'h22,4,1,0, 1,64'h11,3,1, 0,1,1},
            '{1,1,64'h33,6,1,0, 0,64'h0,0,0,  1,0,0},
            '{0,0,64'h0,0,0,1,  0,64'h0,0,0,  1,0,0},
            '{0,1,64'h44,0,1,0, 1,64'h44,0,1, 1,0,0},
            '{0,1,64'h55,5,1,1, 1,64'h55,5,1, 1,0,1},
            '{0,1,64'h66,9,0,1, 1,64'h66,9,0, 1,0,0},
            '{0,0,64'h0,0,0,1,  0,64'h0,0,0,  1,0,0}
        };
        foreach (vecs[i]) begin
            t = vecs[i];
            drive(t.f, t.v, t.wd, t.wa, t.we, t.rdy);
            cycle();
            chk($sformatf("v%0d_wb_valid", i), wb_valid, t.e_valid);
            chk($sformatf("v%0d_exe_ready", i), exe_ready, t.e_ready);
            chk($sformatf("v%0d_skid_full", i), skid_full, t.e_skid);
            chk($sformatf("v%0d_fwd_valid", i), fwd_valid, t.e_fwd);
            chk($sformatf("v%0d_wb_we", i), wb_we, t.e_we);
            if (t.e_valid) begin
                chk($sformatf("v%0d_wb_wdata", i), wb_wdata, t.e_wdata);
                chk($sformatf("v%0d_wb_waddr", i), wb_waddr, t.e_waddr);
                chk($sformatf("v%0d_wb_instr", i), wb_instr,
                    instr_of(t.e_wdata));
                chk($sformatf("v%0d_fwd_addr", i), fwd_addr, t.e_waddr);
                chk($sformatf("v%0d_fwd_data", i), fwd_data, t.e_wdata);
            end
        end

        // Back-to-back stream with WB always ready
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 64'h10 + 64'(i), 5'd1, 1'b1, 1'b1);
            cycle();
            chk($sformatf("b2b%0d_valid", i), wb_valid, 1'b1);
            chk($sformatf("b2b%0d_wdata", i), wb_wdata, 64'h10 + 64'(i));
            chk($sformatf("b2b%0d_skid", i), skid_full, 1'b0);
            chk($sformatf("b2b%0d_ready", i), exe_ready, 1'b1);
        end
        drive(1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b1);
        cycle();
        chk("b2b_drain", wb_valid, 1'b0);

        // Reset mid-stream with head and skid both full
        drive(1'b0, 1'b1, 64'hDEAD, 5'd2, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 64'hBEEF, 5'd3, 1'b1, 1'b0);
        cycle();
        chk("pre_rst_skid", skid_full, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mrst_wb_valid", wb_valid, 1'b0);
        chk("mrst_exe_ready", exe_ready, 1'b1);
        chk("mrst_skid_full", skid_full, 1'b0);
        chk("mrst_wb_we", wb_we, 1'b0);
        chk("mrst_fwd_valid", fwd_valid, 1'b0);
        chk("mrst_wb_wdata", wb_wdata, 64'h0);
        chk("mrst_wb_waddr", wb_waddr, 5'h0);
        chk("mrst_wb_instr", wb_instr, 32'h0);
        @(negedge clock);
        drive(1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        model_q.delete();

        // Randomized traffic against the FIFO model
        for (int c = 0; c < 10000; c++) begin
            chk_model();
            e.wdata = {$urandom, $urandom};
            e.waddr = 5'($urandom_range(0, 31));
            e.we    = 1'($urandom);
            e.instr = instr_of(e.wdata);
            drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60,
                  e.wdata, e.waddr, e.we, $urandom_range(0, 99) < 55);
            in_fire  = exe_valid && (model_q.size() < 2);
            out_fire = wb_ready && (model_q.size() > 0);
            @(posedge clock);
            if (flush) begin
                model_q.delete();
            end else begin
                if (out_fire) void'(model_q.pop_front());
                if (in_fire) model_q.push_back(e);
            end
            @(negedge clock);
        end
        chk_model();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
